// File: rtl/fetch_queue.sv
// Instruction fetch unit: issues one memory read at a time and buffers returned
// words with their addresses in a small FIFO that feeds the IF/ID stage.
module fetch_queue #(
    parameter int          DEPTH    = 2,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fetch_en,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        i_mem_read,
    output logic [15:0] i_mem_address,
    input  logic        i_mem_resp,
    input  logic [15:0] i_mem_rdata,
    output logic        if_valid,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc,
    input  logic        id_ready
);

    localparam int PW = (DEPTH > 2) ? 2 : 1;
    localparam int CW = (DEPTH > 3) ? 3 : 2;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DROP = 2'b10
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     fetch_pc_q, fetch_pc_d;
    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [15:0]     instr_q [DEPTH];
    logic [15:0]     pc_q    [DEPTH];
    logic            push_s;
    logic            pop_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        ptr_inc = (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    // Fetch state machine and fetch address; a redirect always wins the address.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        push_s     = 1'b0;
        case (state_q)
            IDLE: begin
                if (fetch_en && !redirect && (count_q < CW'(DEPTH))) begin
                    state_d = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (redirect) begin
                    // The outstanding read cannot be cancelled, so its word is dropped later.
                    state_d = i_mem_resp ? IDLE : DROP;
                end else if (i_mem_resp) begin
                    push_s     = 1'b1;
                    fetch_pc_d = fetch_pc_q + 16'd2;
                    state_d    = IDLE;
                end else begin
                    state_d = REQ;
                end
            end
            DROP: begin
                state_d = i_mem_resp ? IDLE : DROP;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (redirect) begin
            fetch_pc_d = {redirect_pc[15:1], 1'b0};
        end else begin
            fetch_pc_d = fetch_pc_d;
        end
    end

    assign pop_s = (count_q != {CW{1'b0}}) && id_ready && !redirect;

    // Queue pointer and occupancy update; a redirect flushes everything.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (redirect) begin
            head_d  = {PW{1'b0}};
            tail_d  = {PW{1'b0}};
            count_d = {CW{1'b0}};
        end else begin
            if (push_s) begin
                tail_d = ptr_inc(tail_q);
            end else begin
                tail_d = tail_q;
            end
            if (pop_s) begin
                head_d = ptr_inc(head_q);
            end else begin
                head_d = head_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State, address, pointer and storage registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            head_q     <= {PW{1'b0}};
            tail_q     <= {PW{1'b0}};
            count_q    <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= 16'h0000;
                pc_q[i]    <= 16'h0000;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            if (push_s) begin
                instr_q[tail_q] <= i_mem_rdata;
                pc_q[tail_q]    <= fetch_pc_q;
            end
        end
    end

    assign i_mem_read    = (state_q == REQ) || (state_q == DROP);
    assign i_mem_address = fetch_pc_q;
    assign if_valid      = (count_q != {CW{1'b0}});
    assign if_instr      = instr_q[head_q];
    assign if_pc         = pc_q[head_q];

endmodule

// File: tb/tb_fetch_queue.sv
// Directed and randomized bench for fetch_queue; expectations come from a
// transaction-level model (FIFO queue plus an outstanding-request flag).
module tb_fetch_queue;

    localparam int          DEPTH    = 2;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        i_mem_read;
    logic [15:0] i_mem_address;
    logic        i_mem_resp = 1'b0;
    logic [15:0] i_mem_rdata = 16'h0000;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic        id_ready = 1'b0;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset_n(reset_n), .fetch_en(fetch_en), .redirect(redirect),
        .redirect_pc(redirect_pc), .i_mem_read(i_mem_read), .i_mem_address(i_mem_address),
        .i_mem_resp(i_mem_resp), .i_mem_rdata(i_mem_rdata), .if_valid(if_valid),
        .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: queued {instr, pc} words, fetch address, request bookkeeping.
    logic [31:0] mq[$];
    logic [15:0] m_pc   = RESET_PC;
    bit          m_out  = 1'b0;
    bit          m_disc = 1'b0;
    int          mwait  = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, compare against model, advance model, wait next negedge.
    task automatic step(input bit fe, input bit rd, input logic [15:0] rpc,
                        input bit resp, input logic [15:0] rdata, input bit idr);
        bit          pop;
        bit          push;
        logic [31:0] ent;
        fetch_en = fe; redirect = rd; redirect_pc = rpc;
        i_mem_resp = resp; i_mem_rdata = rdata; id_ready = idr;
        #1;
        check("i_mem_read", 16'(i_mem_read), 16'(m_out));
        check("i_mem_address", i_mem_address, m_pc);
        check("if_valid", 16'(if_valid), 16'(mq.size() != 0));
        if (mq.size() != 0) begin
            check("if_instr", if_instr, mq[0][31:16]);
            check("if_pc", if_pc, mq[0][15:0]);
        end
        pop  = (mq.size() != 0) && idr && !rd;
        push = 1'b0;
        ent  = 32'h0;
        if (m_out) begin
            if (resp) begin
                if (!m_disc && !rd) begin
                    push = 1'b1;
                    ent  = {rdata, m_pc};
                    m_pc = m_pc + 16'd2;
                end
                m_out  = 1'b0;
                m_disc = 1'b0;
            end else if (rd) begin
                m_disc = 1'b1;
            end
        end else if (fe && !rd && (mq.size() < DEPTH)) begin
            m_out = 1'b1;
        end
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back(ent);
        if (rd) begin
            mq.delete();
            m_pc = {rpc[15:1], 1'b0};
        end
        mwait = m_out ? mwait + 1 : 0;
        @(negedge clk);
    endtask

    // Bench-as-memory: answer an outstanding read once it has waited lat cycles.
    task automatic run(input int n, input bit fe, input bit idr, input int lat);
        for (int k = 0; k < n; k++) begin
            step(fe, 1'b0, 16'h0000, m_out && (mwait >= lat), 16'($urandom), idr);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        fetch_en = 1'b0; redirect = 1'b0; i_mem_resp = 1'b0; id_ready = 1'b0;
        #1;
        check("rst_read", 16'(i_mem_read), 16'h0000);
        check("rst_addr", i_mem_address, RESET_PC);
        check("rst_valid", 16'(if_valid), 16'h0000);
        check("rst_instr", if_instr, 16'h0000);
        check("rst_pc", if_pc, 16'h0000);
        mq.delete();
        m_pc = RESET_PC; m_out = 1'b0; m_disc = 1'b0; mwait = 0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // Fill the queue with two words, then stop fetching.
        run(10, 1'b1, 1'b0, 2);
        check("full_head_pc", if_pc, 16'h0000);
        check("full_no_read", 16'(i_mem_read), 16'h0000);

        // One pop frees a slot; the next fetch targets 0x0004.
        run(1, 1'b1, 1'b1, 2);
        check("pop_head_pc", if_pc, 16'h0002);
        run(1, 1'b1, 1'b0, 2);
        check("refetch_read", 16'(i_mem_read), 16'h0001);
        check("refetch_addr", i_mem_address, 16'h0004);

        // Redirect while pending: request held, stale word dropped.
        step(1'b1, 1'b1, 16'h3001, 1'b0, 16'h0000, 1'b0);
        check("drop_read", 16'(i_mem_read), 16'h0001);
        step(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b1, 16'hBEEF, 1'b0);
        check("drop_valid", 16'(if_valid), 16'h0000);
        check("drop_addr", i_mem_address, 16'h3000);
        run(4, 1'b1, 1'b0, 2);

        // Redirect coinciding with a response.
        step(1'b0, 1'b1, 16'h1234, 1'b1, 16'hCAFE, 1'b0);
        check("redir_resp_read", 16'(i_mem_read), 16'h0000);
        check("redir_resp_addr", i_mem_address, 16'h1234);

        // Address wrap from 0xFFFE.
        step(1'b0, 1'b1, 16'hFFFF, 1'b0, 16'h0000, 1'b0);
        run(2, 1'b1, 1'b0, 1);
        check("wrap_addr", i_mem_address, 16'h0000);
        check("wrap_head_pc", if_pc, 16'hFFFE);
        run(3, 1'b1, 1'b1, 1);

        // Reset mid-request, then a stale response.
        do_reset();
        step(1'b0, 1'b0, 16'h0000, 1'b1, 16'h5555, 1'b0);
        check("stale_valid", 16'(if_valid), 16'h0000);
        step(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        check("post_rst_read", 16'(i_mem_read), 16'h0001);
        check("post_rst_addr", i_mem_address, RESET_PC);

        // Randomized traffic with occasional redirects, spurious responses and resets.
        for (int k = 0; k < 600; k++) begin
            bit resp;
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                resp = m_out ? (mwait >= int'($urandom_range(0, 3))) : ($urandom_range(0, 7) == 0);
                step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 16'($urandom),
                     resp, 16'($urandom), $urandom_range(0, 1) == 1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
